mesh_terminal_agent: RTL and testbench

Synthesizable traffic endpoint for one edge terminal of the `mesh_gnrtr` router mesh. It has three parts. The agent accepts packet requests and packs them. The driver queues packed packets in a local FIFO and offers them to the mesh. The monitor pops packets the mesh delivers to this terminal and reports them. One instance sits on each of the 2·ROWS + 2·COLUMS mesh edge ports.

---
 rtl/mesh_terminal_agent.sv | 102 ++++++++++
 tb/tb_mesh_terminal_agent.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mesh_terminal_agent.sv
// mesh_terminal_agent: mesh edge endpoint packing requests into a transmit FIFO and reporting delivered packets
// Ports: clk, reset (async active-low); req_* packet request with req_ready handshake;
// data_out_i_in/pndng_i_in/popin inject packets into the mesh; pndng/data_out/pop drain packets
// the mesh delivers; rx_valid/rx_data/rx_err report each delivery; tx_count/rx_count traffic counters.
module mesh_terminal_agent #(
    parameter int PCKG_SZ    = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int SELF_ROW   = 0,
    parameter int SELF_COL   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_row,
    input  logic [3:0]         req_col,
    input  logic               req_mode,
    input  logic [PCKG_SZ-18:0] req_payload,
    output logic [PCKG_SZ-1:0] data_out_i_in,
    output logic               pndng_i_in,
    input  logic               popin,
    input  logic               pndng,
    input  logic [PCKG_SZ-1:0] data_out,
    output logic               pop,
    output logic               rx_valid,
    output logic [PCKG_SZ-1:0] rx_data,
    output logic               rx_err,
    output logic [15:0]        tx_count,
    output logic [15:0]        rx_count
);
    localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    // Edge coordinates span 0..ROWS+1 / 0..COLUMS+1
    localparam logic [3:0] SR = 4'(SELF_ROW % (ROWS + 2));
    localparam logic [3:0] SC = 4'(SELF_COL % (COLUMS + 2));
    localparam logic IDLE = 1'b0;
    localparam logic WAIT = 1'b1;

    logic [PCKG_SZ-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [15:0]        tx_q, rx_q;
    logic               st_q, st_d;
    logic               rx_valid_q, rx_err_q;
    logic [PCKG_SZ-1:0] rx_data_q;
    logic               push, drain, self_dst, bad_dst;
    logic [PCKG_SZ-1:0] pkt;

    // A request addressed to this terminal itself gets its coordinates swapped
    assign self_dst = req_row == SR && req_col == SC;
    assign pkt = {8'h00, self_dst ? req_col : req_row, self_dst ? req_row : req_col, req_mode, req_payload};
    assign req_ready = cnt_q < CW'(FIFO_DEPTH);
    assign push = req_valid && req_ready;
    assign drain = popin && cnt_q != '0;
    assign pndng_i_in = cnt_q != '0;
    assign data_out_i_in = pndng_i_in ? mem_q[rd_q] : '0;
    // Pop at most every other cycle so the mesh FIFO can refresh pndng
    assign pop = reset && st_q == IDLE && pndng;
    assign bad_dst = data_out[PCKG_SZ-9 -: 4] != SR || data_out[PCKG_SZ-13 -: 4] != SC;
    assign tx_count = tx_q;
    assign rx_count = rx_q;
    assign rx_valid = rx_valid_q;
    assign rx_data = rx_data_q;
    assign rx_err = rx_err_q;

    always_comb begin
        wr_d = push ? (wr_q == AW'(FIFO_DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d = drain ? (rd_q == AW'(FIFO_DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(drain);
        st_d = pop ? WAIT : IDLE;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= pkt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            st_q       <= IDLE;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_q + 16'(drain);
            rx_q       <= rx_q + 16'(pop);
            st_q       <= st_d;
            rx_valid_q <= pop;
            rx_err_q   <= pop && bad_dst;
            if (pop) rx_data_q <= data_out;
        end
    end
endmodule

// File: tb/tb_mesh_terminal_agent.sv
// tb_mesh_terminal_agent: scoreboard bench for mesh_terminal_agent with SELF=(0,1)
module tb_mesh_terminal_agent;
    localparam int W  = 40;
    localparam int PW = W - 17;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic [3:0]    req_row = '0;
    logic [3:0]    req_col = '0;
    logic          req_mode = 1'b0;
    logic [PW-1:0] req_payload = '0;
    logic          popin = 1'b0;
    logic          pndng = 1'b0;
    logic [W-1:0]  data_out = '0;
    logic          req_ready, pndng_i_in, pop, rx_valid, rx_err;
    logic [W-1:0]  data_out_i_in, rx_data;
    logic [15:0]   tx_count, rx_count;

    int total = 0;
    int passed = 0;
    logic [W-1:0] txq[$];
    logic [W:0]   rxq[$];
    int txc = 0;
    int rxc = 0;
    bit wait_m = 1'b0;

    mesh_terminal_agent dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row), .req_col(req_col),
        .req_mode(req_mode), .req_payload(req_payload),
        .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
        .pndng(pndng), .data_out(data_out), .pop(pop),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .tx_count(tx_count), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endfunction

    // Packet the agent should build: self-addressed requests have row/col exchanged
    function automatic logic [W-1:0] pk(logic [3:0] r, logic [3:0] c, logic m, logic [PW-1:0] p);
        logic [3:0] dr, dc;
        dr = r;
        dc = c;
        if (r == 4'd0 && c == 4'd1) begin
            dr = c;
            dc = r;
        end
        return {8'h00, dr, dc, m, p};
    endfunction

    function automatic logic misaddressed(logic [W-1:0] d);
        return d[W-9 -: 4] != 4'd0 || d[W-13 -: 4] != 4'd1;
    endfunction

    // Scoreboard: checks outputs mid-cycle, then applies what the coming edge will do
    initial begin
        logic [W:0] e;
        bit ready_m, exp_pop;
        forever begin
            @(negedge clk);
            if (!reset) begin
                txq.delete();
                rxq.delete();
                txc = 0;
                rxc = 0;
                wait_m = 1'b0;
                chk("rst_pop", pop, 0);
                chk("rst_pndng_i_in", pndng_i_in, 0);
                chk("rst_data_out_i_in", data_out_i_in, 0);
                chk("rst_rx_valid", rx_valid, 0);
                chk("rst_tx_count", tx_count, 0);
                chk("rst_rx_count", rx_count, 0);
            end else begin
                ready_m = txq.size() < 4;
                chk("req_ready", req_ready, ready_m);
                chk("pndng_i_in", pndng_i_in, txq.size() != 0);
                if (txq.size() != 0) chk("tx_head", data_out_i_in, txq[0]);
                chk("tx_count", tx_count, 16'(txc));
                chk("rx_count", rx_count, 16'(rxc));
                if (rxq.size() != 0) begin
                    e = rxq.pop_front();
                    chk("rx_valid", rx_valid, 1);
                    chk("rx_data", rx_data, e[W-1:0]);
                    chk("rx_err", rx_err, e[W]);
                end else chk("rx_idle", rx_valid, 0);
                exp_pop = pndng && !wait_m;
                chk("pop", pop, exp_pop);
                if (exp_pop) begin
                    rxq.push_back({misaddressed(data_out), data_out});
                    rxc++;
                end
                wait_m = exp_pop;
                if (popin && txq.size() != 0) begin
                    void'(txq.pop_front());
                    txc++;
                end
                if (req_valid && ready_m) txq.push_back(pk(req_row, req_col, req_mode, req_payload));
            end
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(logic [3:0] r, logic [3:0] c, logic m, logic [PW-1:0] p);
        req_valid = 1'b1;
        req_row = r;
        req_col = c;
        req_mode = m;
        req_payload = p;
    endtask

    initial begin
        cyc(5);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", req_ready, 1);
        chk("post_reset_pndng", pndng_i_in, 0);
        cyc();
        req(4'd2, 4'd3, 1'b1, PW'(1));
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("pkt_2_3", data_out_i_in, 40'h0023800001);
        chk("pkt_2_3_pndng", pndng_i_in, 1);
        cyc();
        req(4'd0, 4'd1, 1'b0, PW'(8'h5A));
        popin = 1'b1;
        cyc();
        req_valid = 1'b0;
        popin = 1'b0;
        @(negedge clk);
        chk("pkt_self_swap", data_out_i_in, 40'h001000005A);
        cyc();
        popin = 1'b1;
        cyc();
        popin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req(4'($urandom_range(1, 5)), 4'($urandom_range(0, 5)), 1'($urandom), PW'($urandom));
            if (i == 4) begin
                @(negedge clk);
                chk("full_ready", req_ready, 0);
            end
            cyc();
        end
        req_valid = 1'b0;
        popin = 1'b1;
        cyc(4);
        popin = 1'b0;
        @(negedge clk);
        chk("drained_pndng", pndng_i_in, 0);
        chk("drained_tx_count", tx_count, 6);
        cyc();
        pndng = 1'b1;
        data_out = {8'h00, 4'd0, 4'd1, 1'b0, PW'(16'h1234)};
        cyc(6);
        pndng = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("rx_count_3", rx_count, 3);
        cyc();
        pndng = 1'b1;
        data_out = {8'h00, 4'd3, 4'd3, 1'b1, PW'(16'hBEEF)};
        cyc();
        pndng = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("rx_count_4", rx_count, 4);
        cyc();
        repeat (400) begin
            req_valid = 1'($urandom);
            req_row = ($urandom % 4 == 0) ? 4'd0 : 4'($urandom_range(0, 5));
            req_col = ($urandom % 4 == 0) ? 4'd1 : 4'($urandom_range(0, 5));
            req_mode = 1'($urandom);
            req_payload = PW'($urandom);
            popin = ($urandom % 3 == 0);
            pndng = 1'($urandom);
            data_out = W'({$urandom, $urandom});
            if ($urandom % 2 == 0) data_out[W-9 -: 8] = 8'h01;
            cyc();
        end
        req(4'd2, 4'd2, 1'b0, PW'(3));
        pndng = 1'b1;
        popin = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        req_valid = 1'b0;
        pndng = 1'b0;
        @(negedge clk);
        chk("midreset_pndng", pndng_i_in, 0);
        chk("midreset_tx_count", tx_count, 0);
        chk("midreset_ready", req_ready, 1);
        cyc(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
